convolution_coprocessor_mux_seq: RTL and testbench
==================================================

Name: convolution_coprocessor_mux_seq

Overview:
Registered, parametrised N-to-1 operand sequencer for the convolution coprocessor datapath. It selects one of 2**SEL_WIDTH packed input channels, either as a single manual pick or as an automatic wrap-around sweep of a programmed number of channels. Each selected word is streamed out through a one-deep valid/ready output register toward the MAC stage, together with its channel index and a last flag.

Parameters:
DATA_WIDTH, 8, bits per channel word
SEL_WIDTH, 2, selector bits; NUM_INPUTS = 2**SEL_WIDTH (localparam, always a power of two)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  start request, sampled only in IDLE
mode_i  in  1  0 = manual single beat, 1 = auto sweep; sampled with start_i
sel_i  in  SEL_WIDTH  manual channel or sweep start channel; sampled with start_i
count_i  in  SEL_WIDTH+1  sweep length in beats, 1..NUM_INPUTS; sampled with start_i
data_i  in  NUM_INPUTS*DATA_WIDTH  channel k = data_i[k*DATA_WIDTH +: DATA_WIDTH]
ready_i  in  1  downstream accepts data_o when high together with valid_o
valid_o  out  1  data_o/chan_o/last_o hold a beat
data_o  out  DATA_WIDTH  selected word (registered)
chan_o  out  SEL_WIDTH  channel index of data_o
last_o  out  1  final beat of the current operation
busy_o  out  1  operation in progress (RUN state)

Behaviour:
- Reset: rst high at a rising edge forces state IDLE, valid_o=0, data_o=0, chan_o=0, last_o=0, busy_o=0, and clears the internal pointer and remaining counter. Reset mid-operation aborts the operation; the pending beat is discarded.
- States: IDLE, RUN. busy_o=1 exactly in RUN.
- IDLE -> RUN on start_i=1 when:
  - mode_i=0: the operation length is 1 beat at channel sel_i.
  - mode_i=1: the length is count_i beats from channel sel_i.
  - mode_i=1 with count_i=0 or count_i>NUM_INPUTS: the start is ignored and the block stays in IDLE.
- The start cycle loads the first beat. At the edge that samples start_i, the output register takes data_i[sel_i], chan_o=sel_i, and last_o=(length==1). valid_o=1 from the next cycle, so start-to-valid latency is 1 cycle.
- Load condition in RUN: a new beat loads when beats remain AND (valid_o==0 OR ready_i==1).
- Beat sequencing:
  - The pointer increments modulo NUM_INPUTS and wraps from NUM_INPUTS-1 to 0.
  - data_i is sampled at the load edge, not at start.
  - last_o=1 only on the final beat.
- Throughput and stall: with ready_i held high, one beat per cycle. With ready_i low and valid_o high, data_o, chan_o, last_o and valid_o hold stable, and no data_i sampling occurs.
- Completion: when the beat with last_o=1 is accepted (valid_o & ready_i):
  - valid_o=0 and last_o=0 next cycle, and the state returns to IDLE.
  - A start_i in that same cycle is ignored, because start_i is sampled only in IDLE.
- start_i in RUN is ignored. Changes to mode_i, sel_i or count_i in RUN have no effect.
- valid_o never drops without acceptance, except on reset.

Optional Feature:
CONV_MUX_PARITY_EN:
- Defined: adds output parity_o (1 bit), registered alongside data_o and equal to the XOR-reduction (even parity) of data_o. It resets to 0 and follows the same stall and hold rules as data_o.
- Undefined: no parity_o port and no parity logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst high 3 cycles mid-sweep -> valid_o=0, data_o=0, chan_o=0, last_o=0, busy_o=0; a later start works normally.
- Manual pick: data_i={8'h44,8'h33,8'h22,8'h11}, mode_i=0, sel_i=2, start_i pulse, ready_i=1 -> next cycle valid_o=1, data_o=8'h33, chan_o=2, last_o=1; busy_o=0 one cycle later.
- Wrap sweep: mode_i=1, sel_i=3, count_i=4, ready_i=1 -> four consecutive beats with chan_o 3,0,1,2, data 8'h44,8'h11,8'h22,8'h33, last_o only on the 4th.
- Backpressure: sweep sel_i=0, count_i=3; drop ready_i for 2 cycles while valid_o=1 and change data_i meanwhile -> data_o and chan_o hold; the next beats sample data_i at their own load edge; exactly 3 beats are delivered.
- Illegal and ignored starts: count_i=0 or 5 in mode 1 -> stays in IDLE and valid_o stays 0. A start_i pulse during RUN -> no extra beats.
- Parity (CONV_MUX_PARITY_EN defined): select word 8'h07 -> parity_o=1; word 8'h03 -> parity_o=0.

Source files
------------

// File: rtl/convolution_coprocessor_mux_seq_if.sv
// Operand-sequencer bus: start/config from the controller, valid/ready beat stream toward the MAC stage.
// Optional parity_o present when CONV_MUX_PARITY_EN is defined.
interface convolution_coprocessor_mux_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
);
    localparam int NUM_INPUTS = 2 ** SEL_WIDTH;

    logic                               start_i;
    logic                               mode_i;
    logic [SEL_WIDTH-1:0]               sel_i;
    logic [SEL_WIDTH:0]                 count_i;
    logic [NUM_INPUTS*DATA_WIDTH-1:0]   data_i;
    logic                               ready_i;
    logic                               valid_o;
    logic [DATA_WIDTH-1:0]              data_o;
    logic [SEL_WIDTH-1:0]               chan_o;
    logic                               last_o;
    logic                               busy_o;
`ifdef CONV_MUX_PARITY_EN
    logic                               parity_o;
`endif

    modport master (
        output start_i, mode_i, sel_i, count_i, data_i, ready_i,
`ifdef CONV_MUX_PARITY_EN
        input  parity_o,
`endif
        input  valid_o, data_o, chan_o, last_o, busy_o
    );

    modport slave (
        input  start_i, mode_i, sel_i, count_i, data_i, ready_i,
`ifdef CONV_MUX_PARITY_EN
        output parity_o,
`endif
        output valid_o, data_o, chan_o, last_o, busy_o
    );
endinterface

// File: rtl/convolution_coprocessor_mux_seq.sv
// Registered N-to-1 operand sequencer: manual single pick or wrap-around sweep, streamed through a one-deep valid/ready register.
// Define CONV_MUX_PARITY_EN to add a registered even-parity output (parity_o).
module convolution_coprocessor_mux_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    convolution_coprocessor_mux_seq_if.slave bus
);
    localparam int NUM_INPUTS = 2 ** SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] NUM_CNT = (SEL_WIDTH+1)'(NUM_INPUTS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [SEL_WIDTH-1:0]   ptr;
    logic [SEL_WIDTH:0]     remaining;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [SEL_WIDTH-1:0]   chan_q;
    logic                   last_q;
    logic                   valid_q;
`ifdef CONV_MUX_PARITY_EN
    logic                   parity_q;
`endif

    logic [DATA_WIDTH-1:0]  words [NUM_INPUTS];
    logic                   start_ok;
    logic [SEL_WIDTH:0]     start_len;
    logic                   accept;
    logic                   load_en;
    logic [SEL_WIDTH-1:0]   load_chan;
    logic [SEL_WIDTH:0]     load_remaining;

    always_comb begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
            words[k] = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A manual pick is a one-beat sweep; sweeps outside 1..NUM_INPUTS are rejected outright.
    always_comb begin
        start_len = bus.mode_i ? bus.count_i : (SEL_WIDTH+1)'(1);
        start_ok  = bus.start_i && (start_len != '0) && (start_len <= NUM_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_ok) next_state = RUN;
            RUN:  if (accept && last_q) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // load_remaining is the number of beats still owed after the one being loaded.
    always_comb begin
        accept         = valid_q && bus.ready_i;
        load_en        = 1'b0;
        load_chan      = ptr;
        load_remaining = remaining;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load_en        = 1'b1;
                    load_chan      = bus.sel_i;
                    load_remaining = start_len - (SEL_WIDTH+1)'(1);
                end
            end
            RUN: begin
                if ((remaining != '0) && (!valid_q || bus.ready_i)) begin
                    load_en        = 1'b1;
                    load_chan      = ptr;
                    load_remaining = remaining - (SEL_WIDTH+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef CONV_MUX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (load_en) begin
            ptr       <= load_chan + SEL_WIDTH'(1);
            remaining <= load_remaining;
            data_q    <= words[load_chan];
            chan_q    <= load_chan;
            last_q    <= (load_remaining == '0);
            valid_q   <= 1'b1;
`ifdef CONV_MUX_PARITY_EN
            parity_q  <= ^words[load_chan];
`endif
        end else if (accept) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.chan_o  = chan_q;
    assign bus.last_o  = last_q;
    assign bus.busy_o  = (state == RUN);
`ifdef CONV_MUX_PARITY_EN
    assign bus.parity_o = parity_q;
`endif

endmodule

// File: tb/tb_convolution_coprocessor_mux_seq.sv
// Directed bench for convolution_coprocessor_mux_seq: reset, manual pick, wrap sweep, backpressure, ignored starts, optional parity.
module tb_convolution_coprocessor_mux_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    convolution_coprocessor_mux_seq_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) bus ();

    convolution_coprocessor_mux_seq #(.DATA_WIDTH(8), .SEL_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic mode, input logic [1:0] sel,
                                 input logic [2:0] count, input logic ready);
        bus.start_i = start;
        bus.mode_i  = mode;
        bus.sel_i   = sel;
        bus.count_i = count;
        bus.ready_i = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Checks the whole beat register in one go: valid, data, chan, last, busy.
    task automatic checkBeat(input string tag, input logic valid, input logic [7:0] data,
                             input logic [1:0] chan, input logic last, input logic busy);
        checkOutput({tag, ".valid"}, 32'(bus.valid_o), 32'(valid));
        checkOutput({tag, ".data"},  32'(bus.data_o),  32'(data));
        checkOutput({tag, ".chan"},  32'(bus.chan_o),  32'(chan));
        checkOutput({tag, ".last"},  32'(bus.last_o),  32'(last));
        checkOutput({tag, ".busy"},  32'(bus.busy_o),  32'(busy));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        tick();
        tick();
        checkBeat("reset0", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Reset held three cycles in the middle of a stalled sweep.
        applyStimulus(1'b1, 1'b1, 2'd1, 3'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        checkBeat("midsweep", 1'b1, 8'h22, 2'd1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        checkBeat("reset_mid", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        checkBeat("post_reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        // Manual pick of channel 2.
        applyStimulus(1'b1, 1'b0, 2'd2, 3'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
        checkBeat("manual", 1'b1, 8'h33, 2'd2, 1'b1, 1'b1);
        tick();
        checkOutput("manual_done.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("manual_done.busy",  32'(bus.busy_o),  32'd0);

        // Four-beat sweep from channel 3 wraps to 0.
        applyStimulus(1'b1, 1'b1, 2'd3, 3'd4, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
        checkBeat("wrap0", 1'b1, 8'h44, 2'd3, 1'b0, 1'b1);
        tick();
        checkBeat("wrap1", 1'b1, 8'h11, 2'd0, 1'b0, 1'b1);
        tick();
        checkBeat("wrap2", 1'b1, 8'h22, 2'd1, 1'b0, 1'b1);
        tick();
        checkBeat("wrap3", 1'b1, 8'h33, 2'd2, 1'b1, 1'b1);
        tick();
        checkBeat("wrap_done", 1'b0, 8'h33, 2'd2, 1'b0, 1'b0);

        // Backpressure: hold two cycles while data_i changes underneath.
        applyStimulus(1'b1, 1'b1, 2'd0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        checkBeat("bp0", 1'b1, 8'h11, 2'd0, 1'b0, 1'b1);
        bus.data_i = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
        tick();
        checkBeat("bp_hold1", 1'b1, 8'h11, 2'd0, 1'b0, 1'b1);
        tick();
        checkBeat("bp_hold2", 1'b1, 8'h11, 2'd0, 1'b0, 1'b1);
        bus.ready_i = 1'b1;
        tick();
        checkBeat("bp1", 1'b1, 8'hb2, 2'd1, 1'b0, 1'b1);
        tick();
        checkBeat("bp2", 1'b1, 8'hc3, 2'd2, 1'b1, 1'b1);
        tick();
        checkBeat("bp_done", 1'b0, 8'hc3, 2'd2, 1'b0, 1'b0);
        tick();
        checkOutput("bp_no_extra", 32'(bus.valid_o), 32'd0);

        // Illegal sweep lengths are ignored.
        applyStimulus(1'b1, 1'b1, 2'd1, 3'd0, 1'b1);
        tick();
        checkOutput("cnt0.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("cnt0.busy",  32'(bus.busy_o),  32'd0);
        applyStimulus(1'b1, 1'b1, 2'd1, 3'd5, 1'b1);
        tick();
        checkOutput("cnt5.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("cnt5.busy",  32'(bus.busy_o),  32'd0);

        // start_i kept high through a two-beat sweep, including the completing cycle.
        bus.data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        applyStimulus(1'b1, 1'b1, 2'd0, 3'd2, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd3, 3'd4, 1'b1);
        checkBeat("run_start0", 1'b1, 8'h11, 2'd0, 1'b0, 1'b1);
        tick();
        checkBeat("run_start1", 1'b1, 8'h22, 2'd1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
        checkBeat("run_start_done", 1'b0, 8'h22, 2'd1, 1'b0, 1'b0);
        tick();
        checkOutput("run_start_idle", 32'(bus.valid_o), 32'd0);

`ifdef CONV_MUX_PARITY_EN
        bus.data_i = {8'h00, 8'h00, 8'h07, 8'h03};
        applyStimulus(1'b1, 1'b0, 2'd1, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        checkOutput("parity07", 32'(bus.parity_o), 32'd1);
        bus.data_i = {8'h00, 8'h00, 8'h00, 8'h00};
        tick();
        checkOutput("parity07_hold", 32'(bus.parity_o), 32'd1);
        bus.ready_i = 1'b1;
        tick();
        bus.data_i = {8'h00, 8'h00, 8'h07, 8'h03};
        applyStimulus(1'b1, 1'b0, 2'd0, 3'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
        checkOutput("parity03", 32'(bus.parity_o), 32'd0);
        checkOutput("parity03.data", 32'(bus.data_o), 32'h03);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
